scudsp_dma_seq: RTL and testbench

Parametrised DMA transfer sequencer for the SCU DSP. It executes one decoded DMA instruction at a time, moving 32-bit words between the external D0 bus and one DSP data RAM bank, or into program RAM. It drives the bank-local address pointer and generates per-word CT increment pulses. It computes address stepping from a selectable increment table, supports a hold mode that leaves RA0/WA0 unchanged, and reports busy (T0) status to the DSP core.

---
 rtl/scudsp_dma_seq.sv | 216 +++++++++++++++++++++
 tb/tb_scudsp_dma_seq.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scudsp_dma_seq.sv
// SCU DSP DMA transfer sequencer: moves words between the D0 bus and a data RAM bank.
// Define SCUDSP_DMA_PRGRAM_EN to allow D0 -> program RAM transfers (SEL == BANKS).
module scudsp_dma_seq #(
  parameter int unsigned BANKS  = 4,
  parameter int unsigned RAM_AW = 6,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned PRG_AW = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ce,
  input  logic                     i_start,
  input  logic                     i_dir,
  input  logic [3:0]               i_sel,
  input  logic [CNT_W-1:0]         i_cnt,
  input  logic [2:0]               i_addi,
  input  logic                     i_hold,
  input  logic [BANKS*RAM_AW-1:0]  i_ct_in,
  input  logic [ADDR_W-1:0]        i_ra0_in,
  input  logic [ADDR_W-1:0]        i_wa0_in,
  output logic                     o_bus_req,
  output logic                     o_bus_we,
  output logic [ADDR_W-1:0]        o_bus_addr,
  output logic [31:0]              o_bus_do,
  input  logic [31:0]              i_bus_di,
  input  logic                     i_bus_ack,
  output logic [BANKS-1:0]         o_ram_we,
  output logic [BANKS-1:0]         o_ram_re,
  output logic [RAM_AW-1:0]        o_ram_addr,
  output logic [31:0]              o_ram_do,
  input  logic [31:0]              i_ram_di,
  output logic [BANKS-1:0]         o_ct_inc,
  output logic                     o_prg_we,
  output logic [PRG_AW-1:0]        o_prg_addr,
  output logic [ADDR_W-1:0]        o_ra0_out,
  output logic                     o_ra0_we,
  output logic [ADDR_W-1:0]        o_wa0_out,
  output logic                     o_wa0_we,
  output logic                     o_busy,
  output logic                     o_done
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StRdBus, StWrRam, StRdRam, StRdWait, StWrBus, StFin
  } state_e;

  localparam logic [CNT_W:0]  CntOne = 1;
  localparam logic [RAM_AW-1:0] PtrOne = 1;

  state_e r_state, w_state_nxt;

  logic              r_dir;
  logic              r_hold;
  logic [3:0]        r_sel;
  logic [2:0]        r_addi;
  logic [RAM_AW-1:0] r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W:0]    r_cnt;
  logic [31:0]       r_data;

  logic [RAM_AW-1:0] w_ct_sel;
  logic [BANKS-1:0]  w_sel_oh;
  logic [ADDR_W-1:0] w_step;
  logic              w_valid;
  logic              w_last;
  logic              w_advance;

  always_comb begin
    w_ct_sel = '0;
    w_sel_oh = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (i_sel == 4'(b)) w_ct_sel = i_ct_in[b*RAM_AW +: RAM_AW];
      if (r_sel == 4'(b)) w_sel_oh[b] = 1'b1;
    end
  end

  // Increment table: 0, then powers of two 1..64.
  assign w_step = (r_addi == 3'd0) ? '0 : (ADDR_W'(1) << (r_addi - 3'd1));
  assign w_last = (r_cnt == CntOne);

`ifdef SCUDSP_DMA_PRGRAM_EN
  logic              w_prg;
  logic [PRG_AW-1:0] r_pptr;

  assign w_prg      = (r_sel == 4'(BANKS));
  assign w_valid    = (r_sel < 4'(BANKS)) || (w_prg && !r_dir);
  assign o_prg_we   = (r_state == StWrRam) && w_prg;
  assign o_prg_addr = r_pptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pptr <= '0;
    end else if (i_ce) begin
      if (r_state == StIdle && i_start) r_pptr <= '0;
      else if (w_advance)               r_pptr <= r_pptr + PRG_AW'(1);
    end
  end
`else
  assign w_valid    = (r_sel < 4'(BANKS));
  assign o_prg_we   = 1'b0;
  assign o_prg_addr = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else if (i_ce) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_bus_req   = 1'b0;
    o_bus_we    = 1'b0;
    o_ram_we    = '0;
    o_ram_re    = '0;
    o_ct_inc    = '0;
    o_ra0_we    = 1'b0;
    o_wa0_we    = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    w_advance   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_nxt = StLoad;
      end
      StLoad: begin
        o_busy = 1'b1;
        if (!w_valid)   w_state_nxt = StFin;
        else if (r_dir) w_state_nxt = StRdRam;
        else            w_state_nxt = StRdBus;
      end
      StRdBus: begin
        o_busy    = 1'b1;
        o_bus_req = 1'b1;
        if (i_bus_ack) w_state_nxt = StWrRam;
      end
      StWrRam: begin
        // w_sel_oh is all-zero for the program RAM target.
        o_busy      = 1'b1;
        o_ram_we    = w_sel_oh;
        o_ct_inc    = w_sel_oh;
        w_advance   = 1'b1;
        w_state_nxt = w_last ? StFin : StRdBus;
      end
      StRdRam: begin
        o_busy      = 1'b1;
        o_ram_re    = w_sel_oh;
        w_state_nxt = StRdWait;
      end
      StRdWait: begin
        o_busy      = 1'b1;
        o_ct_inc    = w_sel_oh;
        w_state_nxt = StWrBus;
      end
      StWrBus: begin
        o_busy    = 1'b1;
        o_bus_req = 1'b1;
        o_bus_we  = 1'b1;
        if (i_bus_ack) begin
          w_advance   = 1'b1;
          w_state_nxt = w_last ? StFin : StRdRam;
        end
      end
      StFin: begin
        o_done = 1'b1;
        if (w_valid && !r_hold) begin
          o_ra0_we = !r_dir;
          o_wa0_we = r_dir;
        end
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dir  <= 1'b0;
      r_hold <= 1'b0;
      r_sel  <= '0;
      r_addi <= '0;
      r_ptr  <= '0;
      r_addr <= '0;
      r_cnt  <= '0;
      r_data <= '0;
    end else if (i_ce) begin
      if (r_state == StIdle && i_start) begin
        r_dir  <= i_dir;
        r_hold <= i_hold;
        r_sel  <= i_sel;
        r_addi <= i_addi;
        r_ptr  <= w_ct_sel;
        r_addr <= i_dir ? i_wa0_in : i_ra0_in;
        r_cnt  <= (i_cnt == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, i_cnt};
      end
      if (r_state == StRdBus && i_bus_ack) r_data <= i_bus_di;
      if (r_state == StRdWait)             r_data <= i_ram_di;
      if (w_advance) begin
        r_ptr  <= r_ptr + PtrOne;
        r_addr <= r_addr + w_step;
        r_cnt  <= r_cnt - CntOne;
      end
    end
  end

  assign o_bus_addr = r_addr;
  assign o_bus_do   = r_data;
  assign o_ram_do   = r_data;
  assign o_ram_addr = r_ptr;
  assign o_ra0_out  = r_addr;
  assign o_wa0_out  = r_addr;

endmodule

// File: tb/tb_scudsp_dma_seq.sv
// Self-checking bench for scudsp_dma_seq: transfer-level scoreboard plus directed literal checks.
module tb_scudsp_dma_seq;

  localparam int unsigned BANKS  = 4;
  localparam int unsigned RAM_AW = 6;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ADDR_W = 27;
  localparam int unsigned PRG_AW = 8;
  localparam logic [BANKS-1:0] OneB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    i_rst = 1'b1, i_ce = 1'b1, i_start = 1'b0, i_dir = 1'b0;
  logic [3:0]              i_sel = '0;
  logic [CNT_W-1:0]        i_cnt = '0;
  logic [2:0]              i_addi = '0;
  logic                    i_hold = 1'b0;
  logic [BANKS*RAM_AW-1:0] i_ct_in = '0;
  logic [ADDR_W-1:0]       i_ra0_in = '0, i_wa0_in = '0;
  logic [31:0]             i_bus_di = '0, i_ram_di = '0;
  logic                    i_bus_ack = 1'b0;
  logic                    o_bus_req, o_bus_we, o_prg_we, o_ra0_we, o_wa0_we, o_busy, o_done;
  logic [ADDR_W-1:0]       o_bus_addr, o_ra0_out, o_wa0_out;
  logic [31:0]             o_bus_do, o_ram_do;
  logic [BANKS-1:0]        o_ram_we, o_ram_re, o_ct_inc;
  logic [RAM_AW-1:0]       o_ram_addr;
  logic [PRG_AW-1:0]       o_prg_addr;

  scudsp_dma_seq #(
    .BANKS(BANKS), .RAM_AW(RAM_AW), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .PRG_AW(PRG_AW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_ce(i_ce), .i_start(i_start), .i_dir(i_dir),
    .i_sel(i_sel), .i_cnt(i_cnt), .i_addi(i_addi), .i_hold(i_hold), .i_ct_in(i_ct_in),
    .i_ra0_in(i_ra0_in), .i_wa0_in(i_wa0_in), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_do(o_bus_do), .i_bus_di(i_bus_di), .i_bus_ack(i_bus_ack),
    .o_ram_we(o_ram_we), .o_ram_re(o_ram_re), .o_ram_addr(o_ram_addr), .o_ram_do(o_ram_do),
    .i_ram_di(i_ram_di), .o_ct_inc(o_ct_inc), .o_prg_we(o_prg_we), .o_prg_addr(o_prg_addr),
    .o_ra0_out(o_ra0_out), .o_ra0_we(o_ra0_we), .o_wa0_out(o_wa0_out), .o_wa0_we(o_wa0_we),
    .o_busy(o_busy), .o_done(o_done)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] d0_val(input logic [ADDR_W-1:0] a);
    return 32'h5000_0000 ^ 32'(a);
  endfunction

  function automatic logic [31:0] ram_val(input int b, input int a);
    return 32'hA000_0000 + 32'(b) * 32'd256 + 32'(a);
  endfunction

  // Transfer-level model: expected event lists built from the instruction fields.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       data;
  } bus_t;
  typedef struct {
    int          bank;
    logic        prg;
    logic [7:0]  addr;
    logic [31:0] data;
  } ram_t;

  bus_t exp_bus[$], bus_log[$];
  ram_t exp_ram[$], ram_log[$];
  int   exp_ct[$];
  int   exp_wb;
  logic [ADDR_W-1:0] exp_wb_val;
  logic [RAM_AW-1:0] ct[BANKS];

  int done_cnt, wb_cnt, req_cnt;
  logic [ADDR_W-1:0] last_wb;
  logic mon_en = 1'b0, ack_en = 1'b1, rnd_ce = 1'b0;

  task automatic plan(input logic dir, input int sel, input int cnt, input int addi,
                      input logic hold, input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] wa0);
    int n, step, p, pmod;
    logic [ADDR_W-1:0] a;
    logic valid;
    exp_bus.delete(); exp_ram.delete(); exp_ct.delete();
    bus_log.delete(); ram_log.delete();
    done_cnt = 0; wb_cnt = 0; req_cnt = 0; exp_wb = 0; last_wb = '0;
    valid = (sel < BANKS);
`ifdef SCUDSP_DMA_PRGRAM_EN
    if (sel == BANKS && !dir) valid = 1'b1;
`endif
    if (!valid) return;
    n    = (cnt == 0) ? (1 << CNT_W) : cnt;
    step = (addi == 0) ? 0 : (1 << (addi - 1));
    a    = dir ? wa0 : ra0;
    p    = (sel < BANKS) ? int'(ct[sel]) : 0;
    pmod = (sel < BANKS) ? (1 << RAM_AW) : (1 << PRG_AW);
    for (int i = 0; i < n; i++) begin
      if (!dir) begin
        exp_bus.push_back('{addr: a, we: 1'b0, data: 32'h0});
        exp_ram.push_back('{bank: sel, prg: (sel == BANKS), addr: 8'(p), data: d0_val(a)});
      end else begin
        exp_bus.push_back('{addr: a, we: 1'b1, data: ram_val(sel, p)});
      end
      if (sel < BANKS) exp_ct.push_back(sel);
      p = (p + 1) % pmod;
      a = a + ADDR_W'(step);
    end
    if (!hold) begin
      exp_wb     = dir ? 2 : 1;
      exp_wb_val = a;
    end
  endtask

  // D0 responder and clock-enable source: ACK one cycle after REQ is seen.
  logic seen = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    i_ce = rnd_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (ack_en && o_bus_req) begin
      if (seen) begin
        i_bus_ack = 1'b1;
        i_bus_di  = d0_val(o_bus_addr);
        seen      = 1'b0;
      end else begin
        i_bus_ack = 1'b0;
        seen      = 1'b1;
      end
    end else begin
      i_bus_ack = 1'b0;
      seen      = 1'b0;
    end
  end

  // Bank RAM: registered read, garbage on the data lines while the read is being issued.
  logic [31:0] rd_pend = '0;
  always @(negedge clk) begin
    if (|o_ram_re) begin
      for (int b = 0; b < BANKS; b++) if (o_ram_re[b]) rd_pend = ram_val(b, int'(o_ram_addr));
      i_ram_di = 32'hDEAD_BEEF;
    end else begin
      i_ram_di = rd_pend;
    end
  end

  // Compare process: every effective cycle is checked against the model lists.
  bus_t mb;
  ram_t mr;
  int   mbank;
  always @(negedge clk) begin
    if (mon_en && i_ce && !i_rst) begin
      if (o_bus_req) req_cnt++;
      if (o_bus_req && i_bus_ack) begin
        if (exp_bus.size() == 0) fail_now("bus_unexpected");
        else begin
          mb = exp_bus.pop_front();
          chk("bus_addr", 64'(o_bus_addr), 64'(mb.addr));
          chk("bus_we", 64'(o_bus_we), 64'(mb.we));
          if (mb.we) chk("bus_do", 64'(o_bus_do), 64'(mb.data));
        end
        bus_log.push_back('{addr: o_bus_addr, we: o_bus_we, data: o_bus_do});
      end
      if (|o_ram_we || o_prg_we) begin
        if (exp_ram.size() == 0) fail_now("ram_unexpected");
        else begin
          mr = exp_ram.pop_front();
          if (mr.prg) begin
            chk("prg_we", 64'({o_prg_we, o_ram_we}), 64'({1'b1, {BANKS{1'b0}}}));
            chk("prg_addr", 64'(o_prg_addr), 64'(mr.addr));
          end else begin
            chk("ram_we", 64'({o_prg_we, o_ram_we}), 64'({1'b0, OneB << mr.bank}));
            chk("ram_addr", 64'(o_ram_addr), 64'(mr.addr[RAM_AW-1:0]));
          end
          chk("ram_do", 64'(o_ram_do), 64'(mr.data));
        end
        ram_log.push_back('{bank: 0, prg: o_prg_we,
                            addr: o_prg_we ? 8'(o_prg_addr) : 8'(o_ram_addr), data: o_ram_do});
      end
      if (|o_ct_inc) begin
        if (exp_ct.size() == 0) fail_now("ct_unexpected");
        else begin
          mbank = exp_ct.pop_front();
          chk("ct_inc", 64'(o_ct_inc), 64'(OneB << mbank));
        end
      end
      if (o_bus_req || |o_ram_we || |o_ram_re || o_prg_we) chk("busy_active", 64'(o_busy), 64'd1);
      if (o_ra0_we || o_wa0_we) begin
        wb_cnt++;
        last_wb = o_ra0_we ? o_ra0_out : o_wa0_out;
      end
      if (o_done) begin
        done_cnt++;
        chk("done_busy", 64'(o_busy), 64'd0);
        chk("done_left", 64'(exp_bus.size() + exp_ram.size() + exp_ct.size()), 64'd0);
        chk("ra0_we", 64'(o_ra0_we), 64'(exp_wb == 1));
        chk("wa0_we", 64'(o_wa0_we), 64'(exp_wb == 2));
        if (exp_wb == 1) chk("ra0_out", 64'(o_ra0_out), 64'(exp_wb_val));
        if (exp_wb == 2) chk("wa0_out", 64'(o_wa0_out), 64'(exp_wb_val));
      end else if (o_ra0_we || o_wa0_we) begin
        fail_now("wb_without_done");
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic issue(input logic dir, input int sel, input int cnt, input int addi,
                       input logic hold, input logic [ADDR_W-1:0] ra0,
                       input logic [ADDR_W-1:0] wa0, input logic rnd);
    rnd_ce = 1'b0;
    tick(1);
    i_dir = dir; i_sel = 4'(sel); i_cnt = CNT_W'(cnt); i_addi = 3'(addi); i_hold = hold;
    i_ra0_in = ra0; i_wa0_in = wa0;
    for (int b = 0; b < BANKS; b++) i_ct_in[b*RAM_AW +: RAM_AW] = ct[b];
    plan(dir, sel, cnt, addi, hold, ra0, wa0);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    rnd_ce  = rnd;
  endtask

  task automatic wait_done(input int bound, output int cycles, output int gap);
    logic d;
    d = 1'b0; cycles = 0; gap = 0;
    while (!d && cycles < bound) begin
      @(negedge clk);
      cycles++;
      if (i_ce && o_done) d = 1'b1;
      else if (i_ce && !o_busy) gap++;
    end
    if (!d) fail_now("done_timeout");
    rnd_ce = 1'b0;
    tick(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({o_bus_req, o_bus_we, o_ram_we, o_ram_re, o_ct_inc, o_prg_we,
                            o_ra0_we, o_wa0_we, o_busy, o_done}), 64'd0);
    chk({tag, "_bus_addr"}, 64'(o_bus_addr), 64'd0);
    chk({tag, "_bus_do"}, 64'(o_bus_do), 64'd0);
    chk({tag, "_ram_do"}, 64'(o_ram_do), 64'd0);
    chk({tag, "_addrs"}, 64'({o_ram_addr, o_prg_addr}), 64'd0);
    chk({tag, "_wb_out"}, {5'd0, o_ra0_out, 5'd0, o_wa0_out}, 64'd0);
  endtask

  initial begin
    int cyc, gap, n;
    for (int b = 0; b < BANKS; b++) ct[b] = '0;
    tick(3);
    i_rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    mon_en = 1'b1;

    // 1: D0 -> bank1, pointer wraps 62, 63, 0.
    ct[1] = 6'd62;
    issue(1'b0, 1, 3, 1, 1'b0, 27'h100, 27'h0, 1'b0);
    wait_done(100, cyc, gap);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_nbus", 64'(bus_log.size()), 64'd3);
    chk("t1_nram", 64'(ram_log.size()), 64'd3);
    if (bus_log.size() == 3 && ram_log.size() == 3) begin
      chk("t1_bus2_addr", 64'(bus_log[2].addr), 64'h102);
      chk("t1_ram0_addr", 64'(ram_log[0].addr), 64'd62);
      chk("t1_ram2_addr", 64'(ram_log[2].addr), 64'd0);
      chk("t1_ram1_data", 64'(ram_log[1].data), 64'h5000_0101);
    end
    chk("t1_wb", 64'(last_wb), 64'h103);

    // 2: bank2 -> D0, step 4, random clock enable.
    ct[2] = 6'd5;
    issue(1'b1, 2, 2, 3, 1'b0, 27'h0, 27'h20, 1'b1);
    wait_done(200, cyc, gap);
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
    chk("t2_nbus", 64'(bus_log.size()), 64'd2);
    if (bus_log.size() == 2) begin
      chk("t2_w0_addr", 64'(bus_log[0].addr), 64'h20);
      chk("t2_w0_data", 64'(bus_log[0].data), 64'hA000_0205);
      chk("t2_w1_addr", 64'(bus_log[1].addr), 64'h24);
      chk("t2_w1_data", 64'(bus_log[1].data), 64'hA000_0206);
    end
    chk("t2_wb", 64'(last_wb), 64'h28);

    // 3: count 0 means 256 words, zero step.
    ct[0] = 6'd10;
    issue(1'b0, 0, 0, 0, 1'b0, 27'h3C0, 27'h0, 1'b0);
    wait_done(2000, cyc, gap);
    chk("t3_nbus", 64'(bus_log.size()), 64'd256);
    chk("t3_busy_gap", 64'(gap), 64'd0);
    chk("t3_wb", 64'(last_wb), 64'h3C0);

    // 4: hold mode, random clock enable.
    ct[3] = 6'd20;
    issue(1'b0, 3, 4, 2, 1'b1, 27'h500, 27'h0, 1'b1);
    wait_done(400, cyc, gap);
    chk("t4_nram", 64'(ram_log.size()), 64'd4);
    chk("t4_wb_cnt", 64'(wb_cnt), 64'd0);

    // 5: START while busy ignored, then RST while waiting for ACK.
    ack_en = 1'b0;
    issue(1'b0, 0, 4, 1, 1'b0, 27'h40, 27'h0, 1'b0);
    n = 0;
    while (!o_bus_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_req", 64'(o_bus_req), 64'd1);
    tick(2);
    i_dir = 1'b1; i_sel = 4'd1; i_ra0_in = 27'h7777; i_wa0_in = 27'h5555;
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    tick(1);
    @(negedge clk);
    chk("t5_ign_busy", 64'(o_busy), 64'd1);
    chk("t5_ign_addr", 64'(o_bus_addr), 64'h40);
    chk("t5_ign_we", 64'(o_bus_we), 64'd0);
    tick(1);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    @(negedge clk);
    chk_all_zero("t5_rst");
    ack_en = 1'b1;
    ct[3] = 6'd60;
    issue(1'b1, 3, 3, 2, 1'b0, 27'h0, 27'h1000, 1'b0);
    wait_done(100, cyc, gap);
    chk("t5_done_cnt", 64'(done_cnt), 64'd1);
    chk("t5_wb", 64'(last_wb), 64'h1006);

    // 6: SEL == BANKS, D0 -> program RAM.
    issue(1'b0, BANKS, 2, 1, 1'b0, 27'h200, 27'h0, 1'b0);
    wait_done(100, cyc, gap);
    chk("t6_done_cnt", 64'(done_cnt), 64'd1);
`ifdef SCUDSP_DMA_PRGRAM_EN
    chk("t6_nprg", 64'(ram_log.size()), 64'd2);
    if (ram_log.size() == 2) begin
      chk("t6_prg0", 64'({ram_log[0].prg, ram_log[0].addr}), 64'h100);
      chk("t6_prg1", 64'({ram_log[1].prg, ram_log[1].addr}), 64'h101);
    end
    chk("t6_wb", 64'(last_wb), 64'h202);
`else
    chk("t6_req_cnt", 64'(req_cnt), 64'd0);
    chk("t6_latency", 64'(cyc), 64'd2);
    chk("t6_wb_cnt", 64'(wb_cnt), 64'd0);
`endif

    // 7: program RAM as a source is never valid.
    issue(1'b1, BANKS, 2, 1, 1'b0, 27'h0, 27'h300, 1'b0);
    wait_done(100, cyc, gap);
    chk("t7_req_cnt", 64'(req_cnt), 64'd0);
    chk("t7_latency", 64'(cyc), 64'd2);
    chk("t7_wb_cnt", 64'(wb_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
